fu_branch_predictor: RTL and testbench
======================================

Name: fu_branch_predictor

Overview:
- Fetch-side producer of branch predictions, and consumer of resolution feedback from the branch functional unit.
- Direct-mapped BTB with per-entry 2-bit saturating counters.
- Returns a registered prediction (taken, target, hit) one cycle after a fetch lookup.
- Trains on resolved branches via the update_btb/update_pc/branch_target/branch_outcome interface driven by branch resolution.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width; derived.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- fetch_valid  in  1  lookup request this cycle.
- fetch_pc  in  32  PC being fetched; bits [1:0] ignored.
- flush  in  1  squash the prediction being produced this cycle.
- pred_valid  out  1  registered; prediction for the previous cycle's fetch_pc.
- pred_hit  out  1  registered; BTB tag match with valid entry.
- pred_taken  out  1  registered; predicted direction.
- pred_target  out  32  registered; predicted next PC.
- update_btb  in  1  resolution update strobe.
- update_pc  in  32  PC of the resolved branch.
- branch_target  in  32  resolved taken-target (PC+imm).
- branch_outcome  in  1  resolved direction, 1 = taken.
- misprediction  in  1  resolution disagreed with prediction; informational, gates nothing.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry contents: valid (1), tag (TAG_W), target (32), ctr (2). Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (RST=1 at edge):
  - All valid=0, ctr=00, tag/target=0.
  - pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0.
  - RST overrides fetch and update in the same cycle. Reset mid-stream discards any in-flight prediction.
- Lookup (latency 1):
  - At the edge, pred_valid <= fetch_valid & ~flush.
  - hit = valid[idx] & tag match.
  - pred_taken <= hit & ctr[1].
  - pred_target <= pred_taken ? target[idx] : fetch_pc+4. Addition is modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - When pred_valid is next 0, pred_hit, pred_taken and pred_target all register 0.
- Update (applied at the edge when update_btb=1):
  - Hit (valid & tag match):
    - ctr saturating: +1 if taken, -1 if not taken; 11 stays 11, 00 stays 00.
    - target <= branch_target only when branch_outcome=1.
  - Miss or invalid:
    - Allocate (overwrite any alias): valid=1, tag, target=branch_target.
    - ctr = branch_outcome ? 10 : 01.
- Simultaneous lookup and update:
  - Different index: independent.
  - Same index: lookup reads pre-edge array contents (read-before-write), unless BTB_BYPASS_EN.
- flush and fetch_valid together: no prediction produced; array unaffected. An update in the same cycle still applies.
- No stalls or backpressure: a lookup is accepted every cycle, an update every cycle.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: a same-cycle update whose idx matches the fetch idx is forwarded. The registered prediction is computed from the post-update entry value (valid, tag, ctr, target), exactly as if the update had occurred one cycle earlier.
- Undefined: read-before-write as specified above; no forwarding mux.

Test Plan:
- Cold miss: reset; fetch_valid=1, fetch_pc=0x100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x104.
- Allocate taken: update 0x100/0x200/taken; then fetch 0x100 -> pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x200.
- Training:
  - From ctr=10, one not-taken update -> fetch 0x100 gives pred_hit=1, pred_taken=0, pred_target=0x104.
  - Three taken updates -> ctr=11; one not-taken -> ctr=10, still pred_taken=1, target 0x200.
- Alias replacement (ENTRIES=16): after 0x100 allocated, update 0x140 (same idx 0) target 0x300 taken -> fetch 0x100 gives pred_hit=0, target 0x104; fetch 0x140 gives pred_hit=1, target 0x300.
- Flush/reset: fetch 0x100 with flush=1 -> pred_valid=0, all pred outputs 0. Assert RST with a pending hit -> next cycle pred_valid=0, and fetch 0x100 afterward misses.
- Same-cycle update+fetch after reset (0x100/0x200/taken):
  - Without BTB_BYPASS_EN: pred_hit=0, pred_target=0x104.
  - With it: pred_hit=1, pred_taken=1, pred_target=0x200.

Source files
------------

// File: rtl/fu_branch_predictor_if.sv
// Fetch/resolution bus for fu_branch_predictor.
// The master side is the fetch/resolution logic and the slave side is the
// predictor.
interface fu_branch_predictor_if;
  // Lookup request from fetch.
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;

  // Registered prediction returned to fetch.
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  // Resolution feedback from the branch functional unit.
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] branch_target;
  logic        branch_outcome;
  logic        misprediction;

  modport master (
    output fetch_valid, fetch_pc, flush,
    output update_btb, update_pc, branch_target, branch_outcome, misprediction,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  fetch_valid, fetch_pc, flush,
    input  update_btb, update_pc, branch_target, branch_outcome, misprediction,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/fu_branch_predictor.sv
// fu_branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// A lookup returns a registered prediction one cycle later. Resolved
// branches train the table on the same edge they are presented.
// Optional macro BTB_BYPASS_EN: a same-cycle update to the fetched index is
// forwarded into the lookup. When it is undefined, the lookup reads the
// contents from before the edge.
module fu_branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input logic                  CLK,
  input logic                  RST,
  fu_branch_predictor_if.slave bp
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;     // 00 SNT, 01 WNT, 10 WT, 11 ST
  } entry_t;

  entry_t btb [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign fetch_idx = bp.fetch_pc[IDX_W+1:2];
  assign fetch_tag = bp.fetch_pc[31:IDX_W+2];
  assign upd_idx   = bp.update_pc[IDX_W+1:2];
  assign upd_tag   = bp.update_pc[31:IDX_W+2];

  // misprediction is informational only. The byte-offset bits of the PCs do
  // not select anything.
  logic unused_bits;
  assign unused_bits = ^{bp.misprediction, bp.fetch_pc[1:0], bp.update_pc[1:0]};

  entry_t upd_old;
  entry_t upd_new;
  logic   upd_hit;

  // Build the post-update value of the entry addressed by update_pc.
  always_comb begin
    // NOTE: assign every output of an always_comb block first, so that no
    // path through the if/else leaves one unassigned and infers a latch.
    upd_old = btb[upd_idx];
    upd_hit = upd_old.valid && (upd_old.tag == upd_tag);
    upd_new = upd_old;
    if (upd_hit) begin
      if (bp.branch_outcome) begin
        if (upd_old.ctr != 2'b11) upd_new.ctr = upd_old.ctr + 2'd1;
        upd_new.target = bp.branch_target;
      end else if (upd_old.ctr != 2'b00) begin
        upd_new.ctr = upd_old.ctr - 2'd1;
      end
    end else begin
      // A miss allocates the entry and overwrites any alias already there.
      upd_new.valid  = 1'b1;
      upd_new.tag    = upd_tag;
      upd_new.target = bp.branch_target;
      upd_new.ctr    = bp.branch_outcome ? 2'b10 : 2'b01;
    end
  end

  entry_t      look;
  logic        nxt_valid;
  logic        nxt_hit;
  logic        nxt_taken;
  logic [31:0] nxt_target;

  // Select the entry the lookup sees and form the next prediction.
  always_comb begin
`ifdef BTB_BYPASS_EN
    look = (bp.update_btb && (upd_idx == fetch_idx)) ? upd_new : btb[fetch_idx];
`else
    look = btb[fetch_idx];
`endif
    nxt_valid  = bp.fetch_valid && !bp.flush;
    nxt_hit    = nxt_valid && look.valid && (look.tag == fetch_tag);
    nxt_taken  = nxt_hit && look.ctr[1];
    nxt_target = 32'd0;
    if (nxt_valid) nxt_target = nxt_taken ? look.target : bp.fetch_pc + 32'd4;
  end

  // BTB array: cleared on reset, written by a resolution update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: this table is built from flops, not a RAM macro, because reset
      // must clear every entry in a single cycle.
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (bp.update_btb) begin
      // NOTE: sequential state uses non-blocking assignments, so the lookup
      // on this edge still sees the value from before the edge.
      btb[upd_idx] <= upd_new;
    end
  end

  // Prediction output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bp.pred_valid  <= 1'b0;
      bp.pred_hit    <= 1'b0;
      bp.pred_taken  <= 1'b0;
      bp.pred_target <= 32'd0;
    end else begin
      bp.pred_valid  <= nxt_valid;
      bp.pred_hit    <= nxt_hit;
      bp.pred_taken  <= nxt_taken;
      bp.pred_target <= nxt_target;
    end
  end

endmodule

// File: tb/tb_fu_branch_predictor.sv
// Self-checking bench for fu_branch_predictor (ENTRIES=16).
// A directed sequence is followed by randomized traffic. The expected values
// come from a table-level reference model.
module tb_fu_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fu_branch_predictor_if bp ();

  fu_branch_predictor #(.ENTRIES(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bp  (bp)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one row per BTB slot.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> 6);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 32'd0;
      m_ctr[i]    = 0;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    int s;
    s = slot_of(pc);
    if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
      if (taken) begin
        m_ctr[s]    = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        m_target[s] = tgt;
      end else begin
        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end
    end else begin
      m_valid[s]  = 1'b1;
      m_tag[s]    = tag_of(pc);
      m_target[s] = tgt;
      m_ctr[s]    = taken ? 2 : 1;
    end
  endtask

  task automatic model_lookup(input bit fv, input bit fl, input logic [31:0] pc,
                              output bit v, output bit h, output bit t,
                              output logic [31:0] tgt);
    int s;
    s   = slot_of(pc);
    v   = fv && !fl;
    h   = v && m_valid[s] && (m_tag[s] == tag_of(pc));
    t   = h && (m_ctr[s] >= 2);
    tgt = !v ? 32'd0 : (t ? m_target[s] : pc + 32'd4);
  endtask

  // Drive one cycle of stimulus, advance the model, and check the
  // registered prediction after the edge.
  task automatic step(input bit r, input bit fv, input logic [31:0] pc, input bit fl,
                      input bit ub, input logic [31:0] upc, input logic [31:0] utgt,
                      input bit outc, input string name);
    bit          ev, eh, et;
    logic [31:0] etgt;
    @(negedge clk);
    rst               = r;
    bp.fetch_valid    = fv;
    bp.fetch_pc       = pc;
    bp.flush          = fl;
    bp.update_btb     = ub;
    bp.update_pc      = upc;
    bp.branch_target  = utgt;
    bp.branch_outcome = outc;
    bp.misprediction  = 1'($urandom_range(0, 1));
    if (r) begin
      model_clear();
      ev = 1'b0; eh = 1'b0; et = 1'b0; etgt = 32'd0;
    end else begin
`ifdef BTB_BYPASS_EN
      if (ub) model_update(upc, utgt, outc);
      model_lookup(fv, fl, pc, ev, eh, et, etgt);
`else
      model_lookup(fv, fl, pc, ev, eh, et, etgt);
      if (ub) model_update(upc, utgt, outc);
`endif
    end
    @(posedge clk);
    #1;
    check({name, "_valid"},  32'(bp.pred_valid), 32'(ev));
    check({name, "_hit"},    32'(bp.pred_hit),   32'(eh));
    check({name, "_taken"},  32'(bp.pred_taken), 32'(et));
    check({name, "_target"}, bp.pred_target,     etgt);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] upc;
    bp.fetch_valid    = 1'b0;
    bp.fetch_pc       = 32'd0;
    bp.flush          = 1'b0;
    bp.update_btb     = 1'b0;
    bp.update_pc      = 32'd0;
    bp.branch_target  = 32'd0;
    bp.branch_outcome = 1'b0;
    bp.misprediction  = 1'b0;
    model_clear();

    // Directed sequence following the test plan.
    step(1, 1, 32'h100, 0, 1, 32'h100, 32'h200, 1, "reset");
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, "cold_miss");
    check("cold_target_const", bp.pred_target, 32'h104);
    step(0, 0, 0, 0, 1, 32'h100, 32'h200, 1, "alloc_taken");
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, "hit_taken");
    check("hit_target_const", bp.pred_target, 32'h200);
    step(0, 0, 0, 0, 1, 32'h100, 32'h0, 0, "train_nt");
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, "weak_nt");
    check("weak_nt_target_const", bp.pred_target, 32'h104);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h100, 32'h200, 1, "train_t");
    step(0, 0, 0, 0, 1, 32'h100, 32'h0, 0, "train_nt2");
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, "still_taken");
    check("still_taken_const", 32'(bp.pred_taken), 32'd1);
    step(0, 0, 0, 0, 1, 32'h140, 32'h300, 1, "alias_alloc");
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, "alias_old");
    check("alias_old_hit_const", 32'(bp.pred_hit), 32'd0);
    step(0, 1, 32'h140, 0, 0, 0, 0, 0, "alias_new");
    check("alias_new_target_const", bp.pred_target, 32'h300);
    step(0, 1, 32'h140, 1, 0, 0, 0, 0, "flush");
    step(0, 1, 32'h140, 0, 0, 0, 0, 0, "pending_hit");
    step(1, 1, 32'h140, 0, 0, 0, 0, 0, "mid_reset");
    step(0, 1, 32'h140, 0, 0, 0, 0, 0, "post_reset_miss");
    check("post_reset_hit_const", 32'(bp.pred_hit), 32'd0);
    step(0, 1, 32'h100, 0, 1, 32'h100, 32'h200, 1, "same_cycle");
`ifdef BTB_BYPASS_EN
    check("same_cycle_target_const", bp.pred_target, 32'h200);
`else
    check("same_cycle_target_const", bp.pred_target, 32'h104);
`endif
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, "wrap");
    check("wrap_target_const", bp.pred_target, 32'h0);

    // Randomized traffic over a small PC pool, so that hits, aliases and
    // same-index collisions occur often.
    for (int n = 0; n < 800; n++) begin
      pc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) upc = pc;
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), pc,
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), upc,
           $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
